// File: rtl/wino_sched_pkg.sv
// Shared types, constants and packing helpers for the Winograd F(2x2,3x3) tile scheduler.
package wino_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam int TILE_SZ  = 4;
    localparam int OUT_TILE = 2;

    function automatic int out_dim(input int img_dim);
        return img_dim - 2;
    endfunction

    function automatic int tiles_per_side(input int img_dim);
        return (img_dim - 2) / OUT_TILE;
    endfunction

    // Bit offset of element (r,c) in a row-major packed square of side 'side', element width 'w'
    function automatic int px_off(input int r, input int c, input int side, input int w);
        return (r * side + c) * w;
    endfunction

endpackage

// File: rtl/wino_tile_mux.sv
// Combinational 4x4 window select (stride 2) from the latched image, addressed by raster tile index.
module wino_tile_mux
    import wino_sched_pkg::*;
#(
    parameter int IMG_DIM = 12,
    parameter int PIX_W   = 8
) (
    input  logic [IMG_DIM*IMG_DIM*PIX_W-1:0] i_img,
    input  logic [7:0]                       i_tile_idx,
    output logic [TILE_SZ*TILE_SZ*PIX_W-1:0] o_tile
);

    localparam int NT      = tiles_per_side(IMG_DIM);
    localparam int IMG_OW  = $clog2(IMG_DIM*IMG_DIM*PIX_W);
    localparam int TILE_OW = $clog2(TILE_SZ*TILE_SZ*PIX_W);

    int w_tr;
    int w_tc;

    assign w_tr = int'(i_tile_idx) / NT;
    assign w_tc = int'(i_tile_idx) % NT;

    always_comb begin
        o_tile = '0;
        for (int i = 0; i < TILE_SZ; i++) begin
            for (int j = 0; j < TILE_SZ; j++) begin
                o_tile[TILE_OW'(px_off(i, j, TILE_SZ, PIX_W)) +: PIX_W] =
                    i_img[IMG_OW'(px_off(OUT_TILE*w_tr + i, OUT_TILE*w_tc + j, IMG_DIM, PIX_W)) +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/wino_tile_scheduler.sv
// Image -> overlapping 4x4 tiles -> 2x2 results -> feature map sequencer for a Winograd conv engine.
// Optional cycle counter output perf_cycles is built when PERF_CNT_EN is defined.
module wino_tile_scheduler
    import wino_sched_pkg::*;
#(
    parameter int IMG_DIM = 12,
    parameter int PIX_W   = 8,
    parameter int RES_W   = 20,
    parameter int MAX_OUT = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           img_valid,
    output logic                                           img_ready,
    input  logic [IMG_DIM*IMG_DIM*PIX_W-1:0]               img_data,
    output logic                                           tile_valid,
    input  logic                                           tile_ready,
    output logic [16*PIX_W-1:0]                            tile_data,
    output logic [7:0]                                     tile_idx,
    input  logic                                           res_valid,
    input  logic [4*RES_W-1:0]                             res_data,
    output logic                                           fmap_valid,
    input  logic                                           fmap_ready,
    output logic [(IMG_DIM-2)*(IMG_DIM-2)*RES_W-1:0]       fmap_data,
    output logic                                           busy,
    output logic                                           err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                                    perf_cycles
`endif
);

    localparam int OUT_DIM = out_dim(IMG_DIM);
    localparam int NT      = tiles_per_side(IMG_DIM);
    localparam int NTILES  = NT * NT;
    localparam int FM_AW   = $clog2(OUT_DIM*OUT_DIM);

    sched_state_t                     r_state;
    sched_state_t                     w_next;
    logic [IMG_DIM*IMG_DIM*PIX_W-1:0] r_img;
    logic [7:0]                       r_issue_idx;
    logic [7:0]                       r_rcv_idx;
    logic [3:0]                       r_outstanding;
    logic [RES_W-1:0]                 r_fmap [OUT_DIM*OUT_DIM];
    logic                             r_err;
    logic                             w_img_acc;
    logic                             w_tile_acc;
    logic                             w_res_acc;
    logic                             w_last_issue;
    int                               w_rr;
    int                               w_rc;

    assign img_ready    = (r_state == S_IDLE);
    assign fmap_valid   = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;
    assign tile_idx     = r_issue_idx;
    assign tile_valid   = (r_state == S_ISSUE) && (r_outstanding < 4'(MAX_OUT));
    assign w_img_acc    = img_valid && img_ready;
    assign w_tile_acc   = tile_valid && tile_ready;
    // A result with nothing outstanding is dropped (and flagged) whatever the state
    assign w_res_acc    = res_valid && (r_outstanding != 4'd0);
    assign w_last_issue = (r_issue_idx == 8'(NTILES-1));
    assign w_rr         = int'(r_rcv_idx) / NT;
    assign w_rc         = int'(r_rcv_idx) % NT;

    wino_tile_mux #(
        .IMG_DIM (IMG_DIM),
        .PIX_W   (PIX_W)
    ) u_mux (
        .i_img      (r_img),
        .i_tile_idx (r_issue_idx),
        .o_tile     (tile_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_img_acc) w_next = S_ISSUE;
            S_ISSUE: if (w_tile_acc && w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if ((r_outstanding == 4'd0) && (r_rcv_idx == 8'(NTILES))) w_next = S_DONE;
            S_DONE:  if (fmap_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Issue index holds at the last tile so the window mux never addresses past the image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img         <= '0;
            r_issue_idx   <= '0;
            r_rcv_idx     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_img_acc) begin
                r_img         <= img_data;
                r_issue_idx   <= '0;
                r_rcv_idx     <= '0;
                r_outstanding <= '0;
            end else begin
                if (w_tile_acc && !w_last_issue) r_issue_idx <= r_issue_idx + 8'd1;
                if (w_res_acc) r_rcv_idx <= r_rcv_idx + 8'd1;
                case ({w_tile_acc, w_res_acc})
                    2'b10:   r_outstanding <= r_outstanding + 4'd1;
                    2'b01:   r_outstanding <= r_outstanding - 4'd1;
                    default: r_outstanding <= r_outstanding;
                endcase
            end
            if (res_valid && !w_res_acc) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUT_DIM*OUT_DIM; k++) r_fmap[k] <= '0;
        end else if (w_res_acc) begin
            for (int i = 0; i < OUT_TILE; i++) begin
                for (int j = 0; j < OUT_TILE; j++) begin
                    r_fmap[FM_AW'((OUT_TILE*w_rr + i)*OUT_DIM + OUT_TILE*w_rc + j)] <=
                        res_data[(i*OUT_TILE + j)*RES_W +: RES_W];
                end
            end
        end
    end

    for (genvar k = 0; k < OUT_DIM*OUT_DIM; k++) begin : g_fmap
        assign fmap_data[k*RES_W +: RES_W] = r_fmap[k];
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_perf;

    // Counts every ISSUE/DRAIN cycle, so it freezes on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_img_acc) begin
            r_perf <= '0;
        end else if (((r_state == S_ISSUE) || (r_state == S_DRAIN)) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
